// File: rtl/ultrasonic_ranger_if.sv
// Signal bundle between the ranger and its environment.
//   master : the ranger's environment (clock divider, sensor pins, steering logic)
//   slave  : the ranger itself
// Signals:
//   TICK_I   one-cycle measurement start pulse
//   ECHO     raw echo line from the sensor (asynchronous)
//   TRIG     trigger to the sensor
//   DIST_CM  last measured distance in cm (DW bits)
//   DIST_VLD one-cycle pulse when DIST_CM was updated
//   TIMEOUT  one-cycle pulse on missing or saturated echo
//   BUSY     ranging cycle in progress
//   NEAR     DIST_CM < NEAR_CM (only when ULTRASONIC_NEAR_EN is defined)
interface ultrasonic_ranger_if #(
  parameter int DW = 9
);
  logic          TICK_I;
  logic          ECHO;
  logic          TRIG;
  logic [DW-1:0] DIST_CM;
  logic          DIST_VLD;
  logic          TIMEOUT;
  logic          BUSY;
`ifdef ULTRASONIC_NEAR_EN
  logic          NEAR;

  modport master (
    output TICK_I, ECHO,
    input  TRIG, DIST_CM, DIST_VLD, TIMEOUT, BUSY, NEAR
  );
  modport slave (
    input  TICK_I, ECHO,
    output TRIG, DIST_CM, DIST_VLD, TIMEOUT, BUSY, NEAR
  );
`else
  modport master (
    output TICK_I, ECHO,
    input  TRIG, DIST_CM, DIST_VLD, TIMEOUT, BUSY
  );
  modport slave (
    input  TICK_I, ECHO,
    output TRIG, DIST_CM, DIST_VLD, TIMEOUT, BUSY
  );
`endif
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ranging engine. One ranging cycle per TICK_I: raise TRIG for
// TRIG_CYC cycles, wait for the echo to rise, then time the echo by counting
// CYC_PER_CM-cycle slices, so the result comes out directly in whole cm.
// Ports:
//   CLK  system clock
//   RST  synchronous reset, active-high
//   bus  ultrasonic_ranger_if.slave (TICK_I, ECHO in; TRIG, DIST_CM, DIST_VLD,
//        TIMEOUT, BUSY, optional NEAR out)
// Optional feature: define ULTRASONIC_NEAR_EN to add the registered NEAR flag
// (DIST_CM < NEAR_CM), updated on the same edge as DIST_CM.
module ultrasonic_ranger #(
  parameter int TRIG_CYC    = 1000,
  parameter int CYC_PER_CM  = 5800,
  parameter int RISE_TO_CYC = 100000,
  parameter int DIST_MAX    = 400,
  parameter int DW          = 9,
  parameter int NEAR_CM     = 20
) (
  input logic               CLK,
  input logic               RST,
  ultrasonic_ranger_if.slave bus
);

  localparam int TW = $clog2(TRIG_CYC + 1);
  localparam int WW = $clog2(RISE_TO_CYC + 1);
  localparam int SW = $clog2(CYC_PER_CM + 1);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYC - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RISE_TO_CYC - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(CYC_PER_CM - 1);
  localparam logic [DW-1:0] DMAX      = DW'(DIST_MAX);

  // Configuration sanity: DIST_CM must be able to hold DIST_MAX, and a NEAR
  // threshold above saturation would make NEAR meaningless.
  generate
    if ((2 ** DW) <= DIST_MAX) begin : g_bad_dw
      $error("ultrasonic_ranger: DW too narrow for DIST_MAX");
    end
    if (NEAR_CM > DIST_MAX) begin : g_bad_near
      $error("ultrasonic_ranger: NEAR_CM above DIST_MAX");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEAS,
    S_HOLDOFF
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] trig_cnt_q, trig_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [DW-1:0] cm_q, cm_d;
  logic [DW-1:0] dist_q, dist_d;
  logic          vld_q, vld_d;
  logic          to_q, to_d;

  // 2-FF synchronizer plus one more stage for edge detection
  logic echo_m, echo_s, echo_d;
  logic echo_rise, echo_fall;

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;

  // Centimetre count including this cycle's slice. Used for the result so a
  // slice completing on the falling-edge cycle still counts: the reported
  // value is floor(echo_cycles / CYC_PER_CM).
  logic          sub_wrap;
  logic [DW-1:0] cm_inc;

  assign sub_wrap = (sub_q == SUB_LAST);
  assign cm_inc   = sub_wrap ? cm_q + 1'b1 : cm_q;

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    wait_cnt_d = wait_cnt_q;
    sub_d      = sub_q;
    cm_d       = cm_q;
    dist_d     = dist_q;
    vld_d      = 1'b0;
    to_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.TICK_I) begin
          state_d    = S_TRIG;
          trig_cnt_d = '0;
        end
      end
      S_TRIG: begin
        if (trig_cnt_q == TRIG_LAST) begin
          state_d    = S_WAIT_RISE;
          wait_cnt_d = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        // A rise on the last allowed cycle still wins over the timeout.
        if (echo_rise) begin
          state_d = S_MEAS;
          sub_d   = '0;
          cm_d    = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_MEAS: begin
        sub_d = sub_wrap ? '0 : sub_q + 1'b1;
        cm_d  = cm_inc;
        if (echo_fall) begin
          state_d = S_IDLE;
          dist_d  = cm_inc;
          vld_d   = 1'b1;
        end else if (echo_s && (cm_inc == DMAX)) begin
          // Out of range: report the cap, then let the echo finish before
          // accepting another tick so its tail is not mistaken for a new echo.
          state_d = S_HOLDOFF;
          dist_d  = DMAX;
          vld_d   = 1'b1;
          to_d    = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (!echo_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      trig_cnt_q <= '0;
      wait_cnt_q <= '0;
      sub_q      <= '0;
      cm_q       <= '0;
      dist_q     <= '0;
      vld_q      <= 1'b0;
      to_q       <= 1'b0;
      echo_m     <= 1'b0;
      echo_s     <= 1'b0;
      echo_d     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      sub_q      <= sub_d;
      cm_q       <= cm_d;
      dist_q     <= dist_d;
      vld_q      <= vld_d;
      to_q       <= to_d;
      echo_m     <= bus.ECHO;
      echo_s     <= echo_m;
      echo_d     <= echo_s;
    end
  end

  assign bus.TRIG     = (state_q == S_TRIG);
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.DIST_CM  = dist_q;
  assign bus.DIST_VLD = vld_q;
  assign bus.TIMEOUT  = to_q;

`ifdef ULTRASONIC_NEAR_EN
  localparam logic [DW-1:0] NEAR_TH = DW'(NEAR_CM);

  logic near_q, near_d;

  always_comb begin
    near_d = near_q;
    if (vld_d) near_d = (dist_d < NEAR_TH);
  end

  always_ff @(posedge CLK) begin
    if (RST) near_q <= 1'b0;
    else     near_q <= near_d;
  end

  assign bus.NEAR = near_q;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger.sv
module tb_ultrasonic_ranger;

  localparam int TRIG_CYC    = 5;
  localparam int CYC_PER_CM  = 10;
  localparam int RISE_TO_CYC = 50;
  localparam int DIST_MAX    = 20;
  localparam int DW          = 9;
  localparam int NEAR_CM     = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ultrasonic_ranger_if #(.DW(DW)) bus ();

  ultrasonic_ranger #(
    .TRIG_CYC   (TRIG_CYC),
    .CYC_PER_CM (CYC_PER_CM),
    .RISE_TO_CYC(RISE_TO_CYC),
    .DIST_MAX   (DIST_MAX),
    .DW         (DW),
    .NEAR_CM    (NEAR_CM)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_dist = 0;

  // Event counters from a passive monitor
  int   vld_cnt   = 0;
  int   to_cnt    = 0;
  int   both_cnt  = 0;
  int   trig_rise = 0;
  logic trig_prev = 1'b0;

  always @(negedge CLK) begin
    if (bus.DIST_VLD === 1'b1) vld_cnt <= vld_cnt + 1;
    if (bus.TIMEOUT === 1'b1) to_cnt <= to_cnt + 1;
    if (bus.DIST_VLD === 1'b1 && bus.TIMEOUT === 1'b1) both_cnt <= both_cnt + 1;
    if (bus.TRIG === 1'b1 && trig_prev !== 1'b1) trig_rise <= trig_rise + 1;
    trig_prev <= bus.TRIG;
  end

  // Reference model: an echo of w cycles is w/CYC_PER_CM whole cm, capped at
  // DIST_MAX (with TIMEOUT) once it outlasts DIST_MAX full centimetres.
  function automatic int model_dist(input int w);
    if (w > DIST_MAX * CYC_PER_CM) return DIST_MAX;
    return w / CYC_PER_CM;
  endfunction

  function automatic int model_to(input int w);
    return (w == 0 || w > DIST_MAX * CYC_PER_CM) ? 1 : 0;
  endfunction

  // One complete ranging cycle: tick, measure TRIG width, echo of `width`
  // cycles after `delay` cycles, optional extra tick mid-echo, wait for idle.
  task automatic run_cycle(input int delay, input int width, input bit mid_tick,
                           output int trig_w);
    @(negedge CLK); bus.TICK_I = 1'b1;
    @(negedge CLK); bus.TICK_I = 1'b0;
    trig_w = 0;
    for (int i = 0; i < 100 && bus.TRIG === 1'b1; i++) begin
      trig_w++;
      @(negedge CLK);
    end
    repeat (delay) @(negedge CLK);
    if (width > 0) begin
      bus.ECHO = 1'b1;
      for (int i = 0; i < width; i++) begin
        bus.TICK_I = (mid_tick && i == width / 2);
        @(negedge CLK);
      end
      bus.TICK_I = 1'b0;
      bus.ECHO   = 1'b0;
    end
    for (int i = 0; i < 2000 && bus.BUSY !== 1'b0; i++) @(negedge CLK);
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.TICK_I = 1'b0; bus.ECHO = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (bus.TRIG !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b exp=0", bus.TRIG); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    checks++; if (bus.DIST_CM !== '0) begin failures++; $display("FAIL reset_dist got=%0d exp=0", bus.DIST_CM); end
    checks++; if (bus.DIST_VLD !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", bus.DIST_VLD); end
    checks++; if (bus.TIMEOUT !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", bus.TIMEOUT); end
`ifdef ULTRASONIC_NEAR_EN
    checks++; if (bus.NEAR !== 1'b0) begin failures++; $display("FAIL reset_near got=%b exp=0", bus.NEAR); end
`endif
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_normal();
    int tw, v0, t0;
    v0 = vld_cnt; t0 = to_cnt;
    run_cycle(12, 73, 1'b0, tw);
    exp_dist = model_dist(73);
    checks++; if (tw != TRIG_CYC) begin failures++; $display("FAIL normal_trig_width got=%0d exp=%0d", tw, TRIG_CYC); end
    checks++; if (int'(bus.DIST_CM) != exp_dist) begin failures++; $display("FAIL normal_dist got=%0d exp=%0d", bus.DIST_CM, exp_dist); end
    checks++; if (vld_cnt - v0 != 1) begin failures++; $display("FAIL normal_vld_pulses got=%0d exp=1", vld_cnt - v0); end
    checks++; if (to_cnt - t0 != 0) begin failures++; $display("FAIL normal_timeout_pulses got=%0d exp=0", to_cnt - t0); end
  endtask

  task automatic test_random();
    int tw, v0, t0, w, d;
    for (int n = 0; n < 6; n++) begin
      w = $urandom_range(1, 190);
      d = $urandom_range(0, 30);
      v0 = vld_cnt; t0 = to_cnt;
      run_cycle(d, w, 1'b0, tw);
      exp_dist = model_dist(w);
      checks++; if (tw != TRIG_CYC) begin failures++; $display("FAIL rand_trig_width w=%0d got=%0d exp=%0d", w, tw, TRIG_CYC); end
      checks++; if (int'(bus.DIST_CM) != exp_dist) begin failures++; $display("FAIL rand_dist w=%0d got=%0d exp=%0d", w, bus.DIST_CM, exp_dist); end
      checks++; if (vld_cnt - v0 != 1) begin failures++; $display("FAIL rand_vld_pulses w=%0d got=%0d exp=1", w, vld_cnt - v0); end
      checks++; if (to_cnt - t0 != model_to(w)) begin failures++; $display("FAIL rand_timeout w=%0d got=%0d exp=%0d", w, to_cnt - t0, model_to(w)); end
    end
  endtask

  task automatic test_no_echo();
    int v0, t0, k;
    v0 = vld_cnt; t0 = to_cnt;
    @(negedge CLK); bus.TICK_I = 1'b1;
    @(negedge CLK); bus.TICK_I = 1'b0;
    for (int i = 0; i < 100 && bus.TRIG === 1'b1; i++) @(negedge CLK);
    k = 0;
    while (k < 200 && bus.TIMEOUT !== 1'b1) begin
      @(negedge CLK);
      k++;
    end
    checks++; if (k != RISE_TO_CYC) begin failures++; $display("FAIL noecho_timeout_delay got=%0d exp=%0d", k, RISE_TO_CYC); end
    repeat (3) @(negedge CLK);
    checks++; if (to_cnt - t0 != 1) begin failures++; $display("FAIL noecho_timeout_pulses got=%0d exp=1", to_cnt - t0); end
    checks++; if (vld_cnt - v0 != 0) begin failures++; $display("FAIL noecho_vld_pulses got=%0d exp=0", vld_cnt - v0); end
    checks++; if (int'(bus.DIST_CM) != exp_dist) begin failures++; $display("FAIL noecho_dist_held got=%0d exp=%0d", bus.DIST_CM, exp_dist); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL noecho_busy got=%b exp=0", bus.BUSY); end
  endtask

  task automatic test_saturation();
    int v0, b0, k;
    v0 = vld_cnt; b0 = both_cnt;
    @(negedge CLK); bus.TICK_I = 1'b1;
    @(negedge CLK); bus.TICK_I = 1'b0;
    for (int i = 0; i < 100 && bus.TRIG === 1'b1; i++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    bus.ECHO = 1'b1;
    repeat (400) @(negedge CLK);
    exp_dist = model_dist(400);
    checks++; if (int'(bus.DIST_CM) != exp_dist) begin failures++; $display("FAIL sat_dist got=%0d exp=%0d", bus.DIST_CM, exp_dist); end
    checks++; if (both_cnt - b0 != 1) begin failures++; $display("FAIL sat_vld_and_timeout got=%0d exp=1", both_cnt - b0); end
    checks++; if (vld_cnt - v0 != 1) begin failures++; $display("FAIL sat_vld_pulses got=%0d exp=1", vld_cnt - v0); end
    checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL sat_busy_while_echo got=%b exp=1", bus.BUSY); end
    bus.ECHO = 1'b0;
    k = 0;
    while (k < 10 && bus.BUSY !== 1'b0) begin
      @(negedge CLK);
      k++;
    end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL sat_busy_after_echo got=%b exp=0", bus.BUSY); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int tw, v0, r0;
    v0 = vld_cnt; r0 = trig_rise;
    run_cycle(8, 45, 1'b1, tw);
    exp_dist = model_dist(45);
    checks++; if (trig_rise - r0 != 1) begin failures++; $display("FAIL b2b_trig_pulses got=%0d exp=1", trig_rise - r0); end
    checks++; if (vld_cnt - v0 != 1) begin failures++; $display("FAIL b2b_vld_pulses got=%0d exp=1", vld_cnt - v0); end
    checks++; if (int'(bus.DIST_CM) != exp_dist) begin failures++; $display("FAIL b2b_dist got=%0d exp=%0d", bus.DIST_CM, exp_dist); end
  endtask

  task automatic test_reset_mid();
    int tw, v0;
    v0 = vld_cnt;
    @(negedge CLK); bus.TICK_I = 1'b1;
    @(negedge CLK); bus.TICK_I = 1'b0;
    for (int i = 0; i < 100 && bus.TRIG === 1'b1; i++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    bus.ECHO = 1'b1;
    repeat (30) @(negedge CLK);
    checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.BUSY); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (bus.TRIG !== 1'b0) begin failures++; $display("FAIL rstmid_trig got=%b exp=0", bus.TRIG); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.BUSY); end
    checks++; if (bus.DIST_CM !== '0) begin failures++; $display("FAIL rstmid_dist got=%0d exp=0", bus.DIST_CM); end
    RST = 1'b0;
    exp_dist = 0;
    repeat (4) @(negedge CLK);
    bus.ECHO = 1'b0;
    repeat (5) @(negedge CLK);
    checks++; if (vld_cnt - v0 != 0) begin failures++; $display("FAIL rstmid_no_vld got=%0d exp=0", vld_cnt - v0); end
    run_cycle(3, 64, 1'b0, tw);
    exp_dist = model_dist(64);
    checks++; if (tw != TRIG_CYC) begin failures++; $display("FAIL rstmid_next_trig got=%0d exp=%0d", tw, TRIG_CYC); end
    checks++; if (int'(bus.DIST_CM) != exp_dist) begin failures++; $display("FAIL rstmid_next_dist got=%0d exp=%0d", bus.DIST_CM, exp_dist); end
    checks++; if (vld_cnt - v0 != 1) begin failures++; $display("FAIL rstmid_next_vld got=%0d exp=1", vld_cnt - v0); end
  endtask

`ifdef ULTRASONIC_NEAR_EN
  task automatic test_near();
    int tw;
    int widths [2] = '{30, 50};
    for (int n = 0; n < 2; n++) begin
      run_cycle(6, widths[n], 1'b0, tw);
      exp_dist = model_dist(widths[n]);
      checks++; if (int'(bus.DIST_CM) != exp_dist) begin failures++; $display("FAIL near_dist w=%0d got=%0d exp=%0d", widths[n], bus.DIST_CM, exp_dist); end
      checks++; if (bus.NEAR !== (exp_dist < NEAR_CM)) begin failures++; $display("FAIL near_flag w=%0d got=%b exp=%b", widths[n], bus.NEAR, exp_dist < NEAR_CM); end
    end
  endtask
`endif

  initial begin
    bus.TICK_I = 1'b0;
    bus.ECHO   = 1'b0;
    test_reset();
    test_normal();
    test_random();
    test_no_echo();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
`ifdef ULTRASONIC_NEAR_EN
    test_near();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
